md_scheduler: RTL and testbench

Issue controller placed between the E-stage decode and the HI/LO multiply-divide unit. It buffers one multiply/divide/move request at a time through a valid/ready handshake and sequences it into the unit's `start`/`ctrl`/operand inputs. It tracks completion with its own latency counter, combined with the unit's `busy` output. It returns `mfhi`/`mflo` results with a valid pulse, and rejects illegal requests and divide-by-zero requests.

---
 rtl/md_scheduler.sv | 177 +++++++++++++++++
 tb/tb_md_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_scheduler.sv
// Issue controller between E-stage decode and the HI/LO multiply-divide unit.
// Buffers one request, sequences it into the unit, and tracks completion.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | nothing in flight; a full buffer is issued or retired here
// ISSUE  | start/ctrl presented to the unit for one cycle
// WAIT   | mult/div running; latency counter and md_busy both gate done
module md_scheduler #(
    parameter int unsigned MUL_CYC = 5,
    parameter int unsigned DIV_CYC = 10
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    input  logic [3:0]  req_op_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    output logic        req_ready_o,
    input  logic        flush_i,
    output logic        md_start_o,
    output logic [4:0]  md_ctrl_o,
    output logic [31:0] md_a_o,
    output logic [31:0] md_b_o,
    input  logic        md_busy_i,
    input  logic [31:0] md_hi_i,
    input  logic [31:0] md_lo_i,
    output logic        rd_valid_o,
    output logic [31:0] rd_data_o,
    output logic        done_o,
    output logic        err_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    localparam logic [3:0] OP_DIVU = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_MFHI = 4'd5;
    localparam logic [3:0] OP_MTHI = 4'd7;
    localparam logic [3:0] OP_MTLO = 4'd8;

    localparam logic [3:0] MUL_LD = 4'(MUL_CYC);
    localparam logic [3:0] DIV_LD = 4'(DIV_CYC);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;

    logic        buf_full_q;
    logic [3:0]  buf_op_q;
    logic [31:0] buf_a_q;
    logic [31:0] buf_b_q;

    logic        md_start_q;
    logic [4:0]  md_ctrl_q;
    logic [31:0] md_a_q;
    logic [31:0] md_b_q;
    logic        rd_valid_q;
    logic [31:0] rd_data_q;
    logic        done_q;
    logic        err_q;

    logic        accept;
    logic        issue;
    logic        op_legal;
    logic        op_md;
    logic        op_mt;
    logic        div_zero;
    logic        ctrl_md;
    logic        ctrl_div;

    always_comb begin
        accept   = req_valid_i & ~buf_full_q & ~flush_i;
        // flush wins over issue: a request still sitting in the buffer is discarded
        issue    = (state_q == S_IDLE) & buf_full_q & ~flush_i;
        op_legal = (buf_op_q >= 4'd1) && (buf_op_q <= 4'd8);
        op_md    = (buf_op_q >= 4'd1) && (buf_op_q <= 4'd4);
        op_mt    = (buf_op_q == OP_MTHI) || (buf_op_q == OP_MTLO);
        div_zero = ((buf_op_q == OP_DIVU) || (buf_op_q == OP_DIV)) && (buf_b_q == 32'd0);
        ctrl_md  = (md_ctrl_q >= 5'd1) && (md_ctrl_q <= 5'd4);
        ctrl_div = (md_ctrl_q == {1'b0, OP_DIVU}) || (md_ctrl_q == {1'b0, OP_DIV});
        cnt_d    = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            buf_full_q <= 1'b0;
            buf_op_q   <= 4'd0;
            buf_a_q    <= 32'd0;
            buf_b_q    <= 32'd0;
            md_start_q <= 1'b0;
            md_ctrl_q  <= 5'd0;
            md_a_q     <= 32'd0;
            md_b_q     <= 32'd0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            md_start_q <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;

            if (flush_i) begin
                buf_full_q <= 1'b0;
            end else if (accept) begin
                buf_full_q <= 1'b1;
                buf_op_q   <= req_op_i;
                buf_a_q    <= req_a_i;
                buf_b_q    <= req_b_i;
            end else if (issue) begin
                buf_full_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        if (!op_legal || div_zero) begin
                            err_q <= 1'b1;
                        end else if (op_md) begin
                            md_start_q <= 1'b1;
                            md_ctrl_q  <= {1'b0, buf_op_q};
                            md_a_q     <= buf_a_q;
                            md_b_q     <= buf_b_q;
                            state_q    <= S_ISSUE;
                        end else if (op_mt) begin
                            md_ctrl_q  <= {1'b0, buf_op_q};
                            md_a_q     <= buf_a_q;
                            state_q    <= S_ISSUE;
                        end else begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= (buf_op_q == OP_MFHI) ? md_hi_i : md_lo_i;
                        end
                    end
                end
                S_ISSUE: begin
                    md_ctrl_q <= 5'd0;
                    if (ctrl_md) begin
                        cnt_q   <= ctrl_div ? DIV_LD : MUL_LD;
                        state_q <= S_WAIT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_d;
                    // done leaves on the edge the counter reaches zero, if the unit is also idle
                    if ((cnt_d == 4'd0) && !md_busy_i) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o = ~buf_full_q;
    assign busy_o      = (state_q != S_IDLE) | buf_full_q;
    assign md_start_o  = md_start_q;
    assign md_ctrl_o   = md_ctrl_q;
    assign md_a_o      = md_a_q;
    assign md_b_o      = md_b_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Bench for md_scheduler: a behavioural HI/LO unit stub plus a transaction-level
// reference that predicts event cycles and mf data from operation latencies.
module tb_md_scheduler;

    localparam int MUL_CYC = 5;
    localparam int DIV_CYC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        flush = 1'b0;
    logic        req_ready_o, md_start_o, rd_valid_o, done_o, err_o, busy_o;
    logic [4:0]  md_ctrl_o;
    logic [31:0] md_a_o, md_b_o, rd_data_o;
    logic        md_busy;
    logic [31:0] md_hi = 32'd0;
    logic [31:0] md_lo = 32'd0;

    md_scheduler #(.MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_op_i(req_op),
        .req_a_i(req_a), .req_b_i(req_b), .req_ready_o(req_ready_o), .flush_i(flush),
        .md_start_o(md_start_o), .md_ctrl_o(md_ctrl_o), .md_a_o(md_a_o), .md_b_o(md_b_o),
        .md_busy_i(md_busy), .md_hi_i(md_hi), .md_lo_i(md_lo), .rd_valid_o(rd_valid_o),
        .rd_data_o(rd_data_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // {hi, lo} produced by a mult/div, straight from the arithmetic definition
    function automatic logic [63:0] md_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        int qa, qb;
        logic [63:0] r;
        r = 64'd0;
        case (op)
            4'd1: begin ua = a; ub = b; r = ua * ub; end
            4'd2: begin sa = $signed(a); sb = $signed(b); r = sa * sb; end
            4'd3: r = {a % b, a / b};
            4'd4: begin qa = $signed(a); qb = $signed(b); r = {32'(qa % qb), 32'(qa / qb)}; end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // HI/LO unit stub: results land at the start edge, busy for busy_len_cfg cycles
    int busy_len_cfg = 0;
    int busy_cnt = 0;
    assign md_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (md_start_o) begin
            {md_hi, md_lo} <= md_calc(md_ctrl_o[3:0], md_a_o, md_b_o);
            busy_cnt <= busy_len_cfg;
        end else begin
            if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
            if (md_ctrl_o == 5'd7) md_hi <= md_a_o;
            if (md_ctrl_o == 5'd8) md_lo <= md_a_o;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_start = 0, n_ctrl = 0, n_done = 0, n_err = 0, n_rd = 0;
    int c_start = 0, c_mt = 0, c_done = 0, c_err = 0, c_rd = 0;
    logic [4:0]  s_ctrl = 5'd0, mt_ctrl = 5'd0;
    logic [31:0] s_a = 0, s_b = 0, mt_a = 0, rd_d = 0;
    always @(negedge clk) begin
        if (md_start_o) begin
            n_start <= n_start + 1; c_start <= cyc;
            s_ctrl <= md_ctrl_o; s_a <= md_a_o; s_b <= md_b_o;
        end
        if (md_ctrl_o != 5'd0) begin
            n_ctrl <= n_ctrl + 1;
            if (!md_start_o) begin c_mt <= cyc; mt_ctrl <= md_ctrl_o; mt_a <= md_a_o; end
        end
        if (done_o)     begin n_done <= n_done + 1; c_done <= cyc; end
        if (err_o)      begin n_err <= n_err + 1; c_err <= cyc; end
        if (rd_valid_o) begin n_rd <= n_rd + 1; c_rd <= cyc; rd_d <= rd_data_o; end
    end

    logic [31:0] ref_hi = 32'd0;
    logic [31:0] ref_lo = 32'd0;

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy_o && t < 60) begin
            @(posedge clk); #1; t++;
        end
        chk(tag, (t < 60) ? 64'd1 : 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int blen);
        int k, b_start, b_ctrl, b_done, b_err, b_rd, lat, exp_j;
        logic bad, is_md, is_mt;
        logic [63:0] r;
        busy_len_cfg = blen;
        b_start = n_start; b_ctrl = n_ctrl; b_done = n_done; b_err = n_err; b_rd = n_rd;
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        chk("pre_ready", req_ready_o, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = cyc;
        chk("acc_full", req_ready_o, 0);
        wait_idle("op_timeout");
        is_md = (op >= 4'd1) && (op <= 4'd4);
        is_mt = (op == 4'd7) || (op == 4'd8);
        bad   = (op == 4'd0) || (op > 4'd8) || (((op == 4'd3) || (op == 4'd4)) && (b == 32'd0));
        if (bad) begin
            chk("err_cnt",    n_err - b_err, 1);
            chk("err_cyc",    c_err - k, 1);
            chk("bad_start",  n_start - b_start, 0);
            chk("bad_ctrl",   n_ctrl - b_ctrl, 0);
            chk("bad_rd",     n_rd - b_rd, 0);
            chk("bad_done",   n_done - b_done, 0);
        end else if (is_md) begin
            lat = (op >= 4'd3) ? DIV_CYC : MUL_CYC;
            exp_j = 2 + ((blen + 1 > lat) ? blen + 1 : lat);
            chk("md_start_cnt", n_start - b_start, 1);
            chk("md_start_cyc", c_start - k, 1);
            chk("md_ctrl",      s_ctrl, {1'b0, op});
            chk("md_a",         s_a, a);
            chk("md_b",         s_b, b);
            chk("md_ctrl_len",  n_ctrl - b_ctrl, 1);
            chk("done_cnt",     n_done - b_done, 1);
            chk("done_cyc",     c_done - k, exp_j);
            chk("md_err",       n_err - b_err, 0);
            r = md_calc(op, a, b);
            ref_hi = r[63:32];
            ref_lo = r[31:0];
        end else if (is_mt) begin
            chk("mt_start",    n_start - b_start, 0);
            chk("mt_cyc",      c_mt - k, 1);
            chk("mt_ctrl",     mt_ctrl, {1'b0, op});
            chk("mt_a",        mt_a, a);
            chk("mt_ctrl_len", n_ctrl - b_ctrl, 1);
            chk("mt_done",     n_done - b_done, 0);
            if (op == 4'd7) ref_hi = a; else ref_lo = a;
        end else begin
            chk("mf_cnt",  n_rd - b_rd, 1);
            chk("mf_cyc",  c_rd - k, 1);
            chk("mf_data", rd_d, (op == 4'd5) ? ref_hi : ref_lo);
            chk("mf_ctrl", n_ctrl - b_ctrl, 0);
        end
    endtask

    initial begin
        int k, acc, b_done, b_rd;
        logic was_ready;
        logic [31:0] hi0, lo0, a, b;
        logic [3:0] op;
        logic [63:0] r;

        // reset held with a request present
        reset = 1'b0; req_valid = 1'b1; req_op = 4'd5;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready_o, 1);
        chk("rst_busy",  busy_o, 0);
        chk("rst_outs",  {md_start_o, md_ctrl_o, rd_valid_o, done_o, err_o}, 0);
        chk("rst_data",  {md_a_o, md_b_o}, 0);
        chk("rst_rd",    rd_data_o, 0);
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_no_acc", busy_o, 0);

        // mult with a realistic busy, then read both halves
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 4);
        chk("mul_lat", c_done - c_start, 6);
        run_op(4'd6, 0, 0, 0);
        chk("mflo_val", rd_d, 32'hFFFF_FFFA);
        run_op(4'd5, 0, 0, 0);
        chk("mfhi_val", rd_d, 32'hFFFF_FFFF);

        // divide by zero leaves HI/LO alone
        hi0 = md_hi; lo0 = md_lo;
        run_op(4'd4, 32'd7, 32'd0, 3);
        chk("dz_hilo", {md_hi, md_lo}, {hi0, lo0});

        // queued mfhi behind a divu
        busy_len_cfg = 0;
        b_done = n_done; b_rd = n_rd;
        req_op = 4'd3; req_a = 32'd100; req_b = 32'd7; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0; k = cyc;
        repeat (4) begin @(posedge clk); #1; end
        req_op = 4'd5; req_valid = 1'b1;
        chk("q_ready", req_ready_o, 1);
        @(posedge clk); #1; req_valid = 1'b0;
        wait_idle("q_timeout");
        chk("q_done",    n_done - b_done, 1);
        chk("q_rd_cnt",  n_rd - b_rd, 1);
        chk("q_rd_cyc",  c_rd - c_done, 1);
        chk("q_rd_data", rd_d, 32'd2);
        ref_hi = 32'd2; ref_lo = 32'd14;

        // queued mflo flushed during WAIT
        busy_len_cfg = 2;
        b_done = n_done; b_rd = n_rd;
        req_op = 4'd3; req_a = 32'd100; req_b = 32'd7; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0; k = cyc;
        repeat (4) begin @(posedge clk); #1; end
        req_op = 4'd6; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        chk("fl_full", req_ready_o, 0);
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("fl_ready", req_ready_o, 1);
        wait_idle("fl_timeout");
        chk("fl_done",     n_done - b_done, 1);
        chk("fl_done_cyc", c_done - k, 2 + DIV_CYC);
        chk("fl_no_rd",    n_rd - b_rd, 0);

        // mthi then mfhi as early as possible
        b_rd = n_rd;
        req_op = 4'd7; req_a = 32'h1234_5678; req_valid = 1'b1;
        @(posedge clk); #1; k = cyc;
        req_op = 4'd5;
        acc = -1;
        for (int i = 0; i < 6; i++) begin
            was_ready = req_ready_o;
            @(posedge clk); #1;
            if (was_ready) begin acc = cyc; break; end
        end
        req_valid = 1'b0;
        chk("mv_acc_cyc", acc - k, 2);
        wait_idle("mv_timeout");
        chk("mv_rd_cnt",  n_rd - b_rd, 1);
        chk("mv_rd_cyc",  c_rd - k, 3);
        chk("mv_rd_data", rd_d, 32'h1234_5678);
        ref_hi = 32'h1234_5678;

        // reset three cycles into a div WAIT
        busy_len_cfg = 0;
        b_done = n_done; b_rd = n_rd;
        req_op = 4'd4; req_a = 32'd50; req_b = 32'hFFFF_FFFD; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0; k = cyc;
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        req_op = 4'd6; req_valid = 1'b1;
        chk("rm_ready", req_ready_o, 1);
        @(posedge clk); #1; req_valid = 1'b0;
        chk("rm_acc", req_ready_o, 0);
        wait_idle("rm_timeout");
        repeat (12) begin @(posedge clk); #1; end
        chk("rm_no_done", n_done - b_done, 0);
        chk("rm_rd_cnt",  n_rd - b_rd, 1);
        r = md_calc(4'd4, 32'd50, 32'hFFFF_FFFD);
        ref_hi = r[63:32]; ref_lo = r[31:0];
        chk("rm_rd_data", rd_d, 32'hFFFF_FFF0);

        // randomized single-request traffic
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 11));
            if (op > 4'd8) op = 4'($urandom_range(9, 15));
            if ($urandom_range(0, 7) == 0) op = 4'd0;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'd0;
            if (op == 4'd4 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            run_op(op, a, b, $urandom_range(0, 14));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
